// File: rtl/sodor_dbg_pkg.sv
// Shared types and constants for the Sodor debug-path boot loader.
package sodor_dbg_pkg;

  localparam int unsigned DBG_ADDR_W = 5;
  localparam int unsigned DBG_CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN
  } dbg_state_t;

  // Bits needed to hold a settle delay of 'hold' cycles; never narrower than 1.
  function automatic int unsigned hold_cnt_width(input int unsigned hold);
    if (hold == 0) begin
      return 1;
    end
    return $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/sodor_hold_counter.sv
// Down-counter for the settle delay between the last preload write and core release.
module sodor_hold_counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  // Load takes priority; otherwise count down while enabled, parking at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/sodor_debug_loader.sv
// Boot sequencer: holds the core in reset, replays register-preload commands onto the
// debug write port one per cycle, then releases core reset after a settle delay.
module sodor_debug_loader
  import sodor_dbg_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DBG_ADDR_W-1:0] cmd_addr,
  input  logic [XLEN-1:0]       cmd_data,
  input  logic                  cmd_last,
  input  logic                  restart,
  output logic [DBG_ADDR_W-1:0] ddpath_addr,
  output logic [XLEN-1:0]       ddpath_wdata,
  output logic                  ddpath_wen,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DBG_CNT_W-1:0]  wr_count
);

  localparam int unsigned         HoldW    = hold_cnt_width(HOLD_CYCLES);
  localparam logic [HoldW-1:0]    HoldLoad = HoldW'(HOLD_CYCLES);
  localparam logic [DBG_CNT_W-1:0] CntMax  = '1;

  dbg_state_t state_q, state_d;

  logic                  accept;
  logic                  write_ok;
  logic                  hold_load;
  logic                  hold_en;
  logic                  hold_zero;

  logic [DBG_ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic                  wen_q;
  logic                  core_reset_q;
  logic                  err_q;
  logic [DBG_CNT_W-1:0]  wr_count_q;

  // restart wins over a command presented in the same cycle.
  assign accept    = cmd_valid && cmd_ready && !restart;
  // Writes to x0 are swallowed: accepted but never strobed.
  assign write_ok  = accept && (cmd_addr != '0);
  assign hold_load = accept && cmd_last;
  assign hold_en   = (state_q == HOLD);

  sodor_hold_counter #(
    .WIDTH (HoldW)
  ) u_hold_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (hold_load),
    .enable     (hold_en),
    .load_value (HoldLoad),
    .zero       (hold_zero)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            state_d = cmd_last ? HOLD : LOAD;
          end
        end
        HOLD: begin
          if (hold_zero) begin
            state_d = RUN;
          end
        end
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: cmd_ready = 1'b1;
      LOAD: begin
        cmd_ready = 1'b1;
        busy      = 1'b1;
      end
      HOLD:    busy = 1'b1;
      RUN:     done = 1'b1;
      default: ;
    endcase
  end

  // Debug-path write port; address/data hold between strobes and survive restart.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      wen_q <= write_ok;
      if (write_ok) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_data;
      end
    end
  end

  // Write counter (saturating) and sticky x0-write error; both cleared by restart.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else if (restart) begin
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (write_ok && (wr_count_q != CntMax)) begin
        wr_count_q <= wr_count_q + 1'b1;
      end
      if (accept && (cmd_addr == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Core reset is a flop tracking the upcoming state, so it changes with the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      core_reset_q <= 1'b1;
    end else begin
      core_reset_q <= (state_d != RUN);
    end
  end

  assign ddpath_addr  = addr_q;
  assign ddpath_wdata = wdata_q;
  assign ddpath_wen   = wen_q;
  assign core_reset   = core_reset_q;
  assign err          = err_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_sodor_debug_loader.sv
// Self-checking bench: two loaders (settle delay 4 and 0) share one stimulus stream and are
// compared every cycle against a timing-level model, plus directed literal checks.
module tb_sodor_debug_loader;

  localparam int unsigned XLEN = 32;
  localparam int HA = 4;
  localparam int HB = 0;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_last  = 1'b0;
  logic        restart   = 1'b0;
  logic [4:0]  cmd_addr  = '0;
  logic [31:0] cmd_data  = '0;

  logic        a_ready, a_wen, a_crst, a_busy, a_done, a_err;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic [5:0]  a_cnt;
  logic        b_ready, b_wen, b_crst, b_busy, b_done, b_err;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic [5:0]  b_cnt;

  always #5 clock = ~clock;

  sodor_debug_loader #(.XLEN(XLEN), .HOLD_CYCLES(HA)) dut_a (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_last(cmd_last), .restart(restart),
    .ddpath_addr(a_addr), .ddpath_wdata(a_data), .ddpath_wen(a_wen), .core_reset(a_crst),
    .busy(a_busy), .done(a_done), .err(a_err), .wr_count(a_cnt)
  );

  sodor_debug_loader #(.XLEN(XLEN), .HOLD_CYCLES(HB)) dut_b (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_last(cmd_last), .restart(restart),
    .ddpath_addr(b_addr), .ddpath_wdata(b_data), .ddpath_wen(b_wen), .core_reset(b_crst),
    .busy(b_busy), .done(b_done), .err(b_err), .wr_count(b_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks only what happened (accepted commands, when the last one was taken),
  // and derives every output from cycle arithmetic.
  int          m_edges;
  int          m_rel;      // cycle index right after the last-command accept, -1 if none
  bit          m_started;
  bit          m_err;
  bit          m_wen;
  bit          m_acc;
  int          m_cnt;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_edges = 0; m_rel = -1; m_started = 0; m_err = 0; m_wen = 0; m_cnt = 0;
      m_addr = '0; m_data = '0;
    end else begin
      m_acc = cmd_valid && (m_rel < 0) && !restart;
      m_edges++;
      m_wen = 0;
      if (restart) begin
        m_started = 0; m_rel = -1; m_err = 0; m_cnt = 0;
      end else if (m_acc) begin
        m_started = 1;
        if (cmd_addr == 5'd0) begin
          m_err = 1;
        end else begin
          m_wen = 1; m_addr = cmd_addr; m_data = cmd_data;
          if (m_cnt < 63) m_cnt++;
        end
        if (cmd_last) m_rel = m_edges;
      end
    end
  end

  // Released once HOLD_CYCLES+1 cycles have passed after the cycle following the last accept.
  function automatic bit released(input int h);
    return (m_rel >= 0) && (m_edges >= m_rel + h + 1);
  endfunction

  task automatic cmp(input string t, input int h, input logic rdy, input logic bsy,
                     input logic dn, input logic crst, input logic er, input logic wen,
                     input logic [5:0] cnt, input logic [4:0] addr, input logic [31:0] data);
    bit rel;
    rel = released(h);
    check({t, ".cmd_ready"}, rdy, (m_rel < 0));
    check({t, ".busy"}, bsy, (m_started && !rel));
    check({t, ".done"}, dn, rel);
    check({t, ".core_reset"}, crst, !rel);
    check({t, ".err"}, er, m_err);
    check({t, ".wen"}, wen, m_wen);
    check({t, ".wr_count"}, cnt, m_cnt);
    check({t, ".addr"}, addr, m_addr);
    check({t, ".wdata"}, data, m_data);
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      cmp("A", HA, a_ready, a_busy, a_done, a_crst, a_err, a_wen, a_cnt, a_addr, a_data);
      cmp("B", HB, b_ready, b_busy, b_done, b_crst, b_err, b_wen, b_cnt, b_addr, b_data);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [4:0] a, input logic [31:0] d, input logic last);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_last = last;
    step();
    cmd_valid = 1'b0; cmd_last = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst.core_reset", a_crst, 1'b1);
    check("rst.cmd_ready", a_ready, 1'b1);
    check("rst.wen", a_wen, 1'b0);
    reset_n = 1'b1;
    step();

    // Back-to-back preload of x1..x3.
    send(5'd1, 32'h11, 1'b0);
    check("b2b.wen1", a_wen, 1'b1);
    check("b2b.addr1", a_addr, 5'd1);
    check("b2b.data1", a_data, 32'h11);
    send(5'd2, 32'h22, 1'b0);
    check("b2b.addr2", a_addr, 5'd2);
    check("b2b.data2", a_data, 32'h22);
    send(5'd3, 32'h33, 1'b1);                     // accept at T, now in T+1
    check("b2b.wen3", a_wen, 1'b1);
    check("b2b.data3", a_data, 32'h33);
    check("b2b.count", a_cnt, 6'd3);
    check("b2b.h0_crst_t1", b_crst, 1'b1);
    step();                                       // T+2
    check("b2b.h0_crst_t2", b_crst, 1'b0);
    check("b2b.h0_done", b_done, 1'b1);
    repeat (3) step();                            // T+5
    check("b2b.h4_crst_t5", a_crst, 1'b1);
    step();                                       // T+6
    check("b2b.h4_crst_t6", a_crst, 1'b0);
    check("b2b.h4_done", a_done, 1'b1);

    // Restart out of RUN.
    pulse_restart();
    check("rs_run.core_reset", a_crst, 1'b1);
    check("rs_run.done", a_done, 1'b0);
    check("rs_run.count", a_cnt, 6'd0);

    // Write to x0 is swallowed but flagged.
    send(5'd0, 32'hDEAD, 1'b0);
    check("x0.wen", a_wen, 1'b0);
    check("x0.err", a_err, 1'b1);
    check("x0.count", a_cnt, 6'd0);
    check("x0.busy", a_busy, 1'b1);
    send(5'd5, 32'h55, 1'b1);
    check("x0.wen5", a_wen, 1'b1);
    check("x0.addr5", a_addr, 5'd5);
    check("x0.data5", a_data, 32'h55);
    check("x0.count1", a_cnt, 6'd1);
    repeat (5) step();
    check("x0.release", a_crst, 1'b0);
    check("x0.err_sticky", a_err, 1'b1);

    // Single last command with zero settle delay.
    pulse_restart();
    send(5'd7, 32'h7, 1'b1);
    check("h0.wen", b_wen, 1'b1);
    check("h0.addr", b_addr, 5'd7);
    check("h0.crst_t1", b_crst, 1'b1);
    step();
    check("h0.crst_t2", b_crst, 1'b0);

    // restart beats a simultaneous command mid-LOAD.
    pulse_restart();
    send(5'd0, 32'h1, 1'b0);
    send(5'd1, 32'h99, 1'b0);
    cmd_valid = 1'b1; cmd_addr = 5'd2; cmd_data = 32'hAA; restart = 1'b1;
    step();
    cmd_valid = 1'b0; restart = 1'b0;
    check("prio.count", a_cnt, 6'd0);
    check("prio.err", a_err, 1'b0);
    check("prio.ready", a_ready, 1'b1);
    check("prio.busy", a_busy, 1'b0);
    check("prio.wen", a_wen, 1'b0);
    check("prio.addr_kept", a_addr, 5'd1);

    // wr_count saturation.
    for (int i = 0; i < 70; i++) begin
      send(5'((i % 31) + 1), 32'(i), 1'b0);
    end
    check("sat.count", a_cnt, 6'd63);
    send(5'd4, 32'h4, 1'b1);
    check("sat.count_hold", a_cnt, 6'd63);
    repeat (6) step();
    check("sat.release", a_crst, 1'b0);

    // Asynchronous reset mid-cycle.
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.core_reset", a_crst, 1'b1);
    check("arst.ready", a_ready, 1'b1);
    check("arst.count", a_cnt, 6'd0);
    check("arst.addr", a_addr, 5'd0);
    check("arst.data", a_data, 32'd0);
    check("arst.done", a_done, 1'b0);
    check("arst.busy", a_busy, 1'b0);
    check("arst.b_crst", b_crst, 1'b1);
    #3;
    reset_n = 1'b1;
    step();

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      restart   = ($urandom_range(0, 24) == 0);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cmd_data  = $urandom;
      cmd_last  = ($urandom_range(0, 9) == 0);
      step();
    end
    restart = 1'b0; cmd_valid = 1'b0; cmd_last = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
